// File: rtl/lfsr_step_ctrl_pkg.sv
// Shared definitions for the LFSR step sequencer: widths, FSM encodings and the
// 4-bit maximal-length feedback function.
package lfsr_step_ctrl_pkg;

  localparam int LFSR_W = 4;
  localparam int PCNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [PCNT_W-1:0] STEP_CNT_MAX = 5'd31;

  // x^4 + x^3 + 1 in shift-left form; cycles through all 15 nonzero states
  function automatic logic [LFSR_W-1:0] lfsr4_next(input logic [LFSR_W-1:0] q);
    return {q[2:0], q[3] ^ q[0]};
  endfunction

endpackage

// File: rtl/lfsr4_core.sv
// LFSR state register: parallel load has priority over a single feedback step.
module lfsr4_core
  import lfsr_step_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 4'b1111
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] d,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= lfsr4_next(q);
    end
  end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Sequencer for the 4-bit display LFSR: free-run divider, single-step and seed
// load requests, sequence-period measurement and illegal-seed flagging.
module lfsr_step_ctrl
  import lfsr_step_ctrl_pkg::*;
#(
  parameter int                TICK_DIV   = 50000000,
  parameter logic [LFSR_W-1:0] RESET_SEED = 4'b1111
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              run,
  input  logic              step_req,
  input  logic              load_req,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic              step_strobe,
  output logic              running,
  output logic [PCNT_W-1:0] period,
  output logic              period_valid,
  output logic              load_err
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [1:0]        state, state_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic              step_req_d, load_req_d;
  logic              step_edge, load_edge, load_ok, load_bad;
  logic              do_step;
  logic [LFSR_W-1:0] start_val;
  logic [PCNT_W-1:0] step_cnt;
  logic [LFSR_W-1:0] lfsr_nx;

  assign step_edge = step_req & ~step_req_d;
  assign load_edge = load_req & ~load_req_d;
  assign load_ok   = load_edge & (seed_in != '0);
  assign load_bad  = load_edge & (seed_in == '0);
  assign lfsr_nx   = lfsr4_next(lfsr_q);
  assign running   = (state == ST_RUN);

  // A rejected (zero) seed does not disturb the normal step/tick behaviour.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    do_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_n = ST_RUN;
          tick_n  = '0;
        end else if (step_edge) begin
          do_step = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_n = ST_IDLE;
          tick_n  = '0;
        end else if (tick_cnt == TICK_LAST) begin
          do_step = 1'b1;
          tick_n  = '0;
        end else begin
          tick_n = tick_cnt + 1'b1;
        end
      end
      ST_LOAD: begin
        state_n = run ? ST_RUN : ST_IDLE;
        tick_n  = '0;
      end
      default: begin
        state_n = ST_IDLE;
        tick_n  = '0;
      end
    endcase
    if (load_ok) begin
      state_n = ST_LOAD;
      tick_n  = '0;
      do_step = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      step_req_d   <= 1'b0;
      load_req_d   <= 1'b0;
      step_strobe  <= 1'b0;
      period_valid <= 1'b0;
      load_err     <= 1'b0;
      start_val    <= RESET_SEED;
      step_cnt     <= '0;
      period       <= '0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_n;
      step_req_d   <= step_req;
      load_req_d   <= load_req;
      step_strobe  <= do_step;
      load_err     <= load_bad;
      period_valid <= 1'b0;
      if (load_ok) begin
        start_val <= seed_in;
        step_cnt  <= '0;
      end else if (do_step && (step_cnt != STEP_CNT_MAX)) begin
        if (lfsr_nx == start_val) begin
          period       <= step_cnt + 5'd1;
          period_valid <= 1'b1;
          step_cnt     <= '0;
        end else begin
          step_cnt <= step_cnt + 5'd1;
        end
      end
    end
  end

  lfsr4_core #(
    .RESET_SEED(RESET_SEED)
  ) u_core (
    .Clock (Clock),
    .Resetn(Resetn),
    .en    (do_step),
    .load  (load_ok),
    .d     (seed_in),
    .q     (lfsr_q)
  );

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Randomised and directed bench for lfsr_step_ctrl with a sequence-position
// reference model feeding a scoreboard that a separate monitor drains.
module tb_lfsr_step_ctrl;

  localparam int TICK_DIV = 4;
  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_LOAD  = 2;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] seed_in = 4'h0;
  logic [3:0] lfsr_q;
  logic       step_strobe;
  logic       running;
  logic [4:0] period;
  logic       period_valid;
  logic       load_err;

  lfsr_step_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .RESET_SEED(4'b1111)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .run         (run),
    .step_req    (step_req),
    .load_req    (load_req),
    .seed_in     (seed_in),
    .lfsr_q      (lfsr_q),
    .step_strobe (step_strobe),
    .running     (running),
    .period      (period),
    .period_valid(period_valid),
    .load_err    (load_err)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] lfsr;
    logic       running;
    logic       strobe;
    logic       pv;
    logic [4:0] period;
    logic       lerr;
  } snap_t;

  snap_t      exp_q[$];
  logic [3:0] step_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pv_count = 0;
  int         lerr_count = 0;
  bit         done = 0;

  // The maximal-length sequence from 1111, written out once.
  logic [3:0] seq[15] = '{4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC,
                          4'h9, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3, 4'h7};

  int         m_idx, m_anchor, m_steps, m_mode, m_age;
  logic [4:0] m_period;
  bit         m_sprev, m_lprev;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int pos_of(input logic [3:0] v);
    for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_anchor = 0; m_steps = 0; m_mode = M_PAUSE; m_age = 0;
    m_period = 5'd0; m_sprev = 0; m_lprev = 0;
  endtask

  task automatic cycle(input bit rstn, input bit r, input bit s, input bit l, input logic [3:0] sd);
    snap_t e;
    bit se, le, stp;
    @(negedge Clock);
    Resetn = rstn; run = r; step_req = s; load_req = l; seed_in = sd;
    e = '0;
    stp = 0;
    if (!rstn) begin
      model_reset();
    end else begin
      se = s && !m_sprev;
      le = l && !m_lprev;
      if (le && sd != 4'h0) begin
        m_idx = pos_of(sd); m_anchor = m_idx; m_steps = 0; m_mode = M_LOAD;
      end else begin
        if (le) e.lerr = 1'b1;
        if (m_mode == M_PAUSE) begin
          if (r) begin m_mode = M_RUN; m_age = 0; end
          else if (se) stp = 1;
        end else if (m_mode == M_RUN) begin
          if (!r) m_mode = M_PAUSE;
          else begin
            if (m_age % TICK_DIV == TICK_DIV - 1) stp = 1;
            m_age++;
          end
        end else begin
          m_mode = r ? M_RUN : M_PAUSE;
          m_age = 0;
        end
      end
      if (stp) begin
        m_idx = (m_idx + 1) % 15;
        m_steps++;
        e.strobe = 1'b1;
        if (m_idx == m_anchor) begin
          m_period = 5'(m_steps);
          m_steps = 0;
          e.pv = 1'b1;
        end
        step_q.push_back(seq[m_idx]);
      end
      m_sprev = s; m_lprev = l;
    end
    e.lfsr = seq[m_idx];
    e.running = (m_mode == M_RUN);
    e.period = m_period;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 4'h0);
  endtask

  // Monitor: one snapshot per clock, plus a step-event scoreboard on step_strobe.
  initial begin
    snap_t e, a;
    logic [3:0] ev;
    while (!done) begin
      @(posedge Clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{lfsr_q, running, step_strobe, period_valid, period, load_err};
        check("cycle_outputs", 16'(a), 16'(e));
      end
      if (step_strobe === 1'b1) begin
        if (step_q.size() == 0) check("unexpected_step", 16'h1, 16'h0);
        else begin
          ev = step_q.pop_front();
          check("step_value", 16'(lfsr_q), 16'(ev));
        end
      end
      if (period_valid === 1'b1) pv_count++;
      if (load_err === 1'b1) lerr_count++;
    end
  end

  initial begin
    int pv0, le0;
    bit r;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 4'h0);
    idle(20);
    check("reset_lfsr", 16'(lfsr_q), 16'hF);
    check("reset_running", 16'(running), 16'h0);
    check("reset_period", 16'(period), 16'h0);
    check("reset_pulses", 16'(pv_count + lerr_count), 16'h0);

    // Three single-step edges, the first held high for three cycles.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 4'h0);
    cycle(1, 0, 0, 0, 4'h0);
    cycle(1, 0, 1, 0, 4'h0);
    cycle(1, 0, 0, 0, 4'h0);
    cycle(1, 0, 1, 0, 4'h0);
    idle(3);
    check("idle_three_steps", 16'(lfsr_q), 16'hA);

    // Free-run a full period from the reset seed.
    cycle(0, 0, 0, 0, 4'h0);
    pv0 = pv_count;
    for (int i = 0; i < 61; i++) cycle(1, 1, 0, 0, 4'h0);
    idle(3);
    check("run_full_lfsr", 16'(lfsr_q), 16'hF);
    check("run_full_period", 16'(period), 16'd15);
    check("run_full_pv_once", 16'(pv_count - pv0), 16'd1);

    // Reload 0001 while running, then re-measure from it.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 4'h0);
    cycle(1, 1, 0, 1, 4'h1);
    pv0 = pv_count;
    for (int i = 0; i < 61; i++) cycle(1, 1, 0, 0, 4'h0);
    idle(3);
    check("reload_lfsr", 16'(lfsr_q), 16'h1);
    check("reload_period", 16'(period), 16'd15);
    check("reload_pv_once", 16'(pv_count - pv0), 16'd1);

    // Zero seed is rejected; load beats a coincident step.
    le0 = lerr_count;
    cycle(1, 0, 0, 1, 4'h0);
    idle(3);
    check("zero_seed_err", 16'(lerr_count - le0), 16'd1);
    check("zero_seed_lfsr", 16'(lfsr_q), 16'h1);
    cycle(1, 0, 1, 1, 4'h9);
    idle(3);
    check("load_beats_step", 16'(lfsr_q), 16'h9);

    // Asynchronous reset between edges while running.
    cycle(0, 0, 0, 0, 4'h0);
    idle(1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 4'h0);
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    check("async_rst_lfsr", 16'(lfsr_q), 16'hF);
    check("async_rst_running", 16'(running), 16'h0);
    check("async_rst_strobe", 16'(step_strobe), 16'h0);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 0, 4'h0);
    idle(2);
    check("after_rst_two_steps", 16'(lfsr_q), 16'hD);

    // Randomised traffic.
    r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r = !r;
      cycle(($urandom_range(0, 599) != 0), r, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    idle(3);
    @(posedge Clock);
    #2;
    done = 1;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    check("steps_drained", 16'(step_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
